// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer in front of ins_decoder.
//
// Owns the PC and keeps at most one icache request outstanding. Each returned
// word gets a static prediction and is pushed into a circular queue. The head
// entry (ins, pc, prediction) is presented to the decoder. A flush from the ROB
// empties the queue and redirects the PC.
//
// Ports
//   clk_in, rst_in        clock, async active-high reset
//   rdy_in                global ready; low freezes every register
//   ic_req, ic_addr       one-cycle request pulse and its address
//   ic_valid, ic_ins      icache response for the outstanding request
//   iq_valid, iq_ins,     queue head: valid flag, instruction, PC,
//   iq_pc, iq_pred_taken,   predicted direction and predicted next PC
//   iq_pred_pc
//   iq_ready              consumer takes the head this cycle
//   flush_in, flush_pc    redirect request and its target
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready to issue a request when the queue has room
// WAIT  | request outstanding, response will be enqueued
// DROP  | request outstanding but stale (flushed), response discarded
// HALT  | JALR fetched, target unknown; wait for a flush
module fetch_ctrl #(
  parameter int          IQ_DEPTH = 8,
  parameter int          IQ_AW    = 3,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_valid,
  input  logic [31:0] ic_ins,
  output logic        iq_valid,
  output logic [31:0] iq_ins,
  output logic [31:0] iq_pc,
  output logic        iq_pred_taken,
  output logic [31:0] iq_pred_pc,
  input  logic        iq_ready,
  input  logic        flush_in,
  input  logic [31:0] flush_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [6:0]     OP_JAL    = 7'b1101111;
  localparam logic [6:0]     OP_JALR   = 7'b1100111;
  localparam logic [6:0]     OP_BRANCH = 7'b1100011;
  localparam logic [IQ_AW:0] DEPTH_CNT = (IQ_AW + 1)'(IQ_DEPTH);
  localparam logic [IQ_AW:0] CNT_ONE   = (IQ_AW + 1)'(1);
  localparam logic [IQ_AW-1:0] PTR_ONE = IQ_AW'(1);

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             ic_req_q, ic_req_d;
  logic [31:0]      ic_addr_q, ic_addr_d;
  logic [IQ_AW-1:0] head_q, head_d;
  logic [IQ_AW-1:0] tail_q, tail_d;
  logic [IQ_AW:0]   count_q, count_d;

  logic [31:0] ent_ins_q   [IQ_DEPTH];
  logic [31:0] ent_pc_q    [IQ_DEPTH];
  logic        ent_taken_q [IQ_DEPTH];
  logic [31:0] ent_pred_q  [IQ_DEPTH];

  logic        enq;
  logic        deq;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic [6:0]  opcode;
  logic        is_jalr;

  // Static prediction on the returning word; pc_q is the address it came from.
  assign opcode  = ic_ins[6:0];
  assign is_jalr = (opcode == OP_JALR);
  assign imm_j   = {{11{ic_ins[31]}}, ic_ins[31], ic_ins[19:12], ic_ins[20],
                    ic_ins[30:21], 1'b0};
  assign imm_b   = {{19{ic_ins[31]}}, ic_ins[31], ic_ins[7], ic_ins[30:25],
                    ic_ins[11:8], 1'b0};

  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = pc_q + 32'd4;
    case (opcode)
      OP_JAL: begin
        pred_taken = 1'b1;
        pred_pc    = pc_q + imm_j;
      end
      OP_BRANCH: begin
        // backward branches (negative offset) are predicted taken
        if (ic_ins[31]) begin
          pred_taken = 1'b1;
          pred_pc    = pc_q + imm_b;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ic_req_d  = 1'b0;
    ic_addr_d = ic_addr_q;
    enq       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // the slot is reserved here, so the enqueue in WAIT always has room
        if (count_q < DEPTH_CNT) begin
          ic_req_d  = 1'b1;
          ic_addr_d = pc_q;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ic_valid) begin
          enq     = 1'b1;
          pc_d    = pred_pc;
          state_d = is_jalr ? S_HALT : S_IDLE;
        end
      end
      S_DROP: begin
        if (ic_valid) state_d = S_IDLE;
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase

    if (flush_in) begin
      enq       = 1'b0;
      pc_d      = flush_pc;
      ic_req_d  = 1'b0;
      ic_addr_d = ic_addr_q;
      // A response arriving on the flush edge completes the outstanding
      // request, so there is nothing left to drain in that case.
      if ((state_q == S_WAIT || state_q == S_DROP) && !ic_valid) state_d = S_DROP;
      else state_d = S_IDLE;
    end
  end

  always_comb begin
    deq     = iq_valid && iq_ready && !flush_in;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_in) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PTR_ONE;
      if (deq) head_d = head_q + PTR_ONE;
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ic_req_q  <= 1'b0;
      ic_addr_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        ent_ins_q[i]   <= '0;
        ent_pc_q[i]    <= '0;
        ent_taken_q[i] <= 1'b0;
        ent_pred_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ic_req_q  <= ic_req_d;
      ic_addr_q <= ic_addr_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      if (enq) begin
        ent_ins_q[tail_q]   <= ic_ins;
        ent_pc_q[tail_q]    <= pc_q;
        ent_taken_q[tail_q] <= pred_taken;
        ent_pred_q[tail_q]  <= pred_pc;
      end
    end
  end

  // While frozen the pulse is held in ic_req_q and shown once rdy_in returns.
  assign ic_req        = ic_req_q && rdy_in;
  assign ic_addr       = ic_addr_q;
  assign iq_valid      = (count_q != '0);
  assign iq_ins        = ent_ins_q[head_q];
  assign iq_pc         = ent_pc_q[head_q];
  assign iq_pred_taken = ent_taken_q[head_q];
  assign iq_pred_pc    = ent_pred_q[head_q];

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_valid;
  logic [31:0] ic_ins;
  logic        iq_valid;
  logic [31:0] iq_ins;
  logic [31:0] iq_pc;
  logic        iq_pred_taken;
  logic [31:0] iq_pred_pc;
  logic        iq_ready;
  logic        flush_in;
  logic [31:0] flush_pc;

  always #5 clk_in = ~clk_in;

  fetch_ctrl dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .ic_req        (ic_req),
    .ic_addr       (ic_addr),
    .ic_valid      (ic_valid),
    .ic_ins        (ic_ins),
    .iq_valid      (iq_valid),
    .iq_ins        (iq_ins),
    .iq_pc         (iq_pc),
    .iq_pred_taken (iq_pred_taken),
    .iq_pred_pc    (iq_pred_pc),
    .iq_ready      (iq_ready),
    .flush_in      (flush_in),
    .flush_pc      (flush_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        taken;
    logic [31:0] pred;
    logic        halts;
  } vec_t;

  logic [31:0] imem [256];
  logic        ic_hold;
  logic [31:0] req_log [$];
  int          n_chk  = 0;
  int          n_pass = 0;

  // icache model: one-cycle latency, frozen by rdy_in, stall via ic_hold
  logic        s_req, s_valid, s_rdy, s_rst, pend;
  logic [31:0] paddr;
  initial begin
    ic_valid = 1'b0;
    ic_ins   = '0;
    pend     = 1'b0;
    paddr    = '0;
    forever begin
      @(posedge clk_in);
      s_req = ic_req; s_valid = ic_valid; s_rdy = rdy_in; s_rst = rst_in;
      #1;
      if (rst_in || s_rst) begin
        ic_valid = 1'b0;
        pend     = 1'b0;
      end else if (s_rdy) begin
        if (s_valid) ic_valid = 1'b0;
        if (s_req) begin
          pend  = 1'b1;
          paddr = ic_addr;
        end
        if (pend && !ic_hold) begin
          ic_valid = 1'b1;
          ic_ins   = imem[paddr[9:2]];
          pend     = 1'b0;
        end
      end
    end
  end

  // request monitor: logs every address the icache actually accepted
  always @(posedge clk_in) begin
    if (!rst_in && ic_req) req_log.push_back(ic_addr);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] get_req(int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
    rst_in   = 1'b1;
    rdy_in   = 1'b1;
    iq_ready = 1'b0;
    flush_in = 1'b0;
    flush_pc = '0;
    ic_hold  = 1'b0;
    repeat (3) step();
    rst_in = 1'b0;
    req_log.delete();
  endtask

  task automatic deq_one();
    iq_ready = 1'b1;
    step();
    iq_ready = 1'b0;
  endtask

  task automatic flush_to(logic [31:0] addr);
    flush_pc = addr;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
  endtask

  task automatic wait_valid(string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (iq_valid) break;
    end
    chk(name, {31'b0, iq_valid}, 32'd1);
  endtask

  task automatic wait_reqs(int n, string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (req_log.size() >= n) break;
    end
    chk(name, req_log.size(), n);
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0000_0013, 1'b0, 32'h0000_0004, 1'b0};
    vecs[1] = '{32'h0000_0010, 32'h0080_006F, 1'b1, 32'h0000_0018, 1'b0};
    vecs[2] = '{32'h0000_0020, 32'hFE00_0EE3, 1'b1, 32'h0000_001C, 1'b0};
    vecs[3] = '{32'h0000_0020, 32'h0000_0463, 1'b0, 32'h0000_0024, 1'b0};
    vecs[4] = '{32'h0000_0030, 32'h0000_8067, 1'b0, 32'h0000_0034, 1'b1};
    vecs[5] = '{32'h0000_0004, 32'hFF9F_F06F, 1'b1, 32'hFFFF_FFFC, 1'b0};
    vecs[6] = '{32'h0000_0008, 32'hFE00_08E3, 1'b1, 32'hFFFF_FFF8, 1'b0};
    vecs[7] = '{32'h0000_0060, 32'h0000_1463, 1'b0, 32'h0000_0064, 1'b0};
    vecs[8] = '{32'h0000_0080, 32'h7FFF_F06F, 1'b1, 32'h0010_007E, 1'b0};

    // reset values and first-fetch latency, sequential addi stream
    rst_in = 1'b1;
    do_reset();
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("rst_ic_req", {31'b0, ic_req}, 32'd0);
    chk("rst_ic_addr", ic_addr, 32'd0);
    chk("rst_iq_valid", {31'b0, iq_valid}, 32'd0);
    chk("rst_iq_ins", iq_ins, 32'd0);
    chk("rst_iq_pc", iq_pc, 32'd0);
    chk("rst_iq_pred_pc", iq_pred_pc, 32'd0);
    chk("rst_iq_taken", {31'b0, iq_pred_taken}, 32'd0);
    do_reset();
    @(negedge clk_in);
    chk("lat_req_early", {31'b0, ic_req}, 32'd0);
    @(negedge clk_in);
    chk("lat_req", {31'b0, ic_req}, 32'd1);
    chk("lat_addr", ic_addr, 32'd0);
    @(negedge clk_in);
    chk("lat_iq_early", {31'b0, iq_valid}, 32'd0);
    @(negedge clk_in);
    chk("lat_iq", {31'b0, iq_valid}, 32'd1);
    chk("lat_iq_ins", iq_ins, 32'h0000_0013);
    wait_reqs(3, "seq_reqs");
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("seq_addr%0d", k), get_req(k), 32'(4 * k));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      chk($sformatf("seq_pc%0d", k), iq_pc, 32'(4 * k));
      chk($sformatf("seq_pred%0d", k), iq_pred_pc, 32'(4 * k + 4));
      chk($sformatf("seq_taken%0d", k), {31'b0, iq_pred_taken}, 32'd0);
      chk($sformatf("seq_ins%0d", k), iq_ins, 32'h0000_0013);
      deq_one();
    end

    // full queue stops fetch; one dequeue allows exactly one more request
    do_reset();
    repeat (40) step();
    chk("full_reqs", req_log.size(), 8);
    chk("full_last_addr", get_req(7), 32'h0000_001C);
    req_log.delete();
    repeat (10) step();
    chk("full_no_req", req_log.size(), 0);
    deq_one();
    repeat (10) step();
    chk("full_one_req", req_log.size(), 1);
    chk("full_one_addr", get_req(0), 32'h0000_0020);
    @(negedge clk_in);
    chk("full_head_pc", iq_pc, 32'h0000_0004);

    // flush during WAIT, late response dropped, then reset mid-request
    do_reset();
    repeat (7) step();
    @(negedge clk_in);
    ic_hold = 1'b1;
    repeat (6) @(negedge clk_in);
    chk("fl_pre_valid", {31'b0, iq_valid}, 32'd1);
    flush_pc = 32'h0000_0100;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    req_log.delete();
    @(negedge clk_in);
    chk("fl_iq_empty", {31'b0, iq_valid}, 32'd0);
    repeat (5) @(negedge clk_in);
    chk("fl_drop_no_req", req_log.size(), 0);
    ic_hold = 1'b0;
    wait_valid("fl_refill");
    chk("fl_head_pc", iq_pc, 32'h0000_0100);
    chk("fl_req_addr", get_req(0), 32'h0000_0100);
    ic_hold = 1'b1;
    repeat (4) @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    chk("mr_ic_addr", ic_addr, 32'd0);
    chk("mr_iq_valid", {31'b0, iq_valid}, 32'd0);
    chk("mr_ic_req", {31'b0, ic_req}, 32'd0);
    ic_hold = 1'b0;
    step();
    step();
    rst_in = 1'b0;
    req_log.delete();
    wait_reqs(1, "mr_req");
    chk("mr_req_addr", get_req(0), 32'd0);
    wait_valid("mr_refill");
    chk("mr_head_pc", iq_pc, 32'd0);

    // JALR halts fetch; flush resumes; rdy_in freeze
    do_reset();
    imem[2] = 32'h0000_8067;
    repeat (20) step();
    chk("halt_reqs", req_log.size(), 3);
    deq_one();
    deq_one();
    @(negedge clk_in);
    chk("halt_ins", iq_ins, 32'h0000_8067);
    chk("halt_pc", iq_pc, 32'h0000_0008);
    chk("halt_taken", {31'b0, iq_pred_taken}, 32'd0);
    chk("halt_pred", iq_pred_pc, 32'h0000_000C);
    flush_to(32'h0000_0040);
    req_log.delete();
    wait_reqs(2, "rs_reqs");
    chk("rs_addr0", get_req(0), 32'h0000_0040);
    rdy_in   = 1'b0;
    iq_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk($sformatf("frz_valid%0d", k), {31'b0, iq_valid}, 32'd1);
      chk($sformatf("frz_pc%0d", k), iq_pc, 32'h0000_0040);
      chk($sformatf("frz_addr%0d", k), ic_addr, 32'h0000_0044);
    end
    rdy_in   = 1'b1;
    iq_ready = 1'b0;
    @(negedge clk_in);
    chk("frz_head_kept", iq_pc, 32'h0000_0040);
    deq_one();
    @(negedge clk_in);
    chk("frz_next_pc", iq_pc, 32'h0000_0044);
    wait_reqs(3, "frz_reqs");
    chk("frz_addr2", get_req(2), 32'h0000_0048);
    for (int i = 0; i < 20; i++) begin
      if (ic_req) break;
      @(negedge clk_in);
    end
    rdy_in = 1'b0;
    #1;
    chk("frz_req_forced", {31'b0, ic_req}, 32'd0);
    repeat (2) @(negedge clk_in);
    chk("frz_req_held", {31'b0, ic_req}, 32'd0);
    rdy_in = 1'b1;
    #1;
    chk("frz_req_back", {31'b0, ic_req}, 32'd1);
    chk("frz_req_addr", ic_addr, 32'h0000_004C);
    wait_reqs(5, "frz_reqs5");
    chk("frz_addr3", get_req(3), 32'h0000_004C);
    chk("frz_addr4", get_req(4), 32'h0000_0050);

    // prediction table: redirect to each vector PC and inspect the head
    do_reset();
    for (int i = 0; i < 9; i++) begin
      imem[vecs[i].pc[9:2]] = vecs[i].word;
      flush_to(vecs[i].pc);
      req_log.delete();
      wait_valid($sformatf("vec%0d_valid", i));
      chk($sformatf("vec%0d_ins", i), iq_ins, vecs[i].word);
      chk($sformatf("vec%0d_pc", i), iq_pc, vecs[i].pc);
      chk($sformatf("vec%0d_taken", i), {31'b0, iq_pred_taken}, {31'b0, vecs[i].taken});
      chk($sformatf("vec%0d_pred", i), iq_pred_pc, vecs[i].pred);
      if (vecs[i].halts) begin
        repeat (12) step();
        chk($sformatf("vec%0d_halt", i), req_log.size(), 1);
      end else begin
        wait_reqs(2, $sformatf("vec%0d_reqs", i));
        chk($sformatf("vec%0d_next", i), get_req(1), vecs[i].pred);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
